uart_tx_engine: RTL and testbench

Transmit engine of the UART core, the counterpart of the Rx state machine. It accepts one byte per valid/ready handshake and serialises it LSB-first as start bit, 8 data bits, optional parity bit and 1 or 2 stop bits. Each bit lasts OVERSAMPLE pulses of the baudrate generator's oversampling tick. The state register and bit counter are triplicated with majority voting, for upset tolerance. It sits between the Tx buffer/control register block and the Tx pad.

---
 rtl/uart_tx_engine.sv | 156 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per handshake as start, 8 data (LSB first),
// optional parity and 1 or 2 stop bits. State, bit counter, tick counter and stop flag are TMR.
module uart_tx_engine #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Tick_i,
   input  logic [7:0] Data_i,
   input  logic       Valid_i,
   output logic       Ready_o,
   input  logic       p_ParityEnable_i,
   input  logic       p_ParityOdd_i,
   input  logic       StopBits2_i,
   output logic       Tx_o,
   output logic       Done_o,
   output logic [4:0] State_o,
   output logic [3:0] BitCounter_o
);
   // state     | meaning
   // INTERVAL  | idle, line high, ready for a byte
   // STARTBIT  | driving the start bit (0)
   // DATABITS  | driving shift_reg[0], bit counter = data bit index
   // PARITYBIT | driving the latched parity bit
   // STOPBIT   | driving stop bit(s) (1)
   localparam logic [4:0] INTERVAL  = 5'b00001;
   localparam logic [4:0] STARTBIT  = 5'b00010;
   localparam logic [4:0] DATABITS  = 5'b00100;
   localparam logic [4:0] PARITYBIT = 5'b01000;
   localparam logic [4:0] STOPBIT   = 5'b10000;
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   logic [4:0] state_a, state_b, state_c, state_v, state_n;
   logic [3:0] bit_cnt_a, bit_cnt_b, bit_cnt_c, bit_cnt_v, bit_cnt_n;
   logic [3:0] tick_a, tick_b, tick_c, tick_v, tick_n, tick_inc;
   logic       stop2_a, stop2_b, stop2_c, stop2_v, stop2_n;
   logic [7:0] shift_reg;
   logic       parity_q, par_en_q, stop2_en_q;
   logic       tx_q, tx_n, done_q, done_n;
   logic       bit_end, load, shift_en;

   assign state_v   = (state_a & state_b) | (state_b & state_c) | (state_c & state_a);
   assign bit_cnt_v = (bit_cnt_a & bit_cnt_b) | (bit_cnt_b & bit_cnt_c) | (bit_cnt_c & bit_cnt_a);
   assign tick_v    = (tick_a & tick_b) | (tick_b & tick_c) | (tick_c & tick_a);
   assign stop2_v   = (stop2_a & stop2_b) | (stop2_b & stop2_c) | (stop2_c & stop2_a);

   assign bit_end  = Tick_i && (tick_v == TICK_LAST);
   assign tick_inc = bit_end ? 4'd0 : (Tick_i ? tick_v + 4'd1 : tick_v);

   always_comb begin
      state_n   = state_v;
      bit_cnt_n = 4'd0;
      tick_n    = 4'd0;
      stop2_n   = 1'b0;
      tx_n      = 1'b1;
      done_n    = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      case (state_v)
         INTERVAL: begin
            if (Valid_i) begin
               state_n = STARTBIT;
               load    = 1'b1;
            end
         end
         STARTBIT: begin
            tx_n   = 1'b0;
            tick_n = tick_inc;
            if (bit_end) state_n = DATABITS;
         end
         DATABITS: begin
            tx_n      = shift_reg[0];
            tick_n    = tick_inc;
            bit_cnt_n = bit_cnt_v;
            if (bit_end) begin
               shift_en  = 1'b1;
               bit_cnt_n = bit_cnt_v + 4'd1;
               if (bit_cnt_v >= 4'd7) state_n = par_en_q ? PARITYBIT : STOPBIT;
            end
         end
         PARITYBIT: begin
            tx_n   = parity_q;
            tick_n = tick_inc;
            if (bit_end) state_n = STOPBIT;
         end
         STOPBIT: begin
            tick_n  = tick_inc;
            stop2_n = stop2_v;
            if (bit_end) begin
               if (stop2_en_q && !stop2_v) begin
                  stop2_n = 1'b1;
               end else begin
                  stop2_n = 1'b0;
                  state_n = INTERVAL;
                  done_n  = 1'b1;
               end
            end
         end
         // a corrupted (non one-hot) vote falls back to idle with everything cleared
         default: state_n = INTERVAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_a    <= INTERVAL;
         state_b    <= INTERVAL;
         state_c    <= INTERVAL;
         bit_cnt_a  <= 4'd0;
         bit_cnt_b  <= 4'd0;
         bit_cnt_c  <= 4'd0;
         tick_a     <= 4'd0;
         tick_b     <= 4'd0;
         tick_c     <= 4'd0;
         stop2_a    <= 1'b0;
         stop2_b    <= 1'b0;
         stop2_c    <= 1'b0;
         shift_reg  <= 8'd0;
         parity_q   <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_en_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_a   <= state_n;
         state_b   <= state_n;
         state_c   <= state_n;
         bit_cnt_a <= bit_cnt_n;
         bit_cnt_b <= bit_cnt_n;
         bit_cnt_c <= bit_cnt_n;
         tick_a    <= tick_n;
         tick_b    <= tick_n;
         tick_c    <= tick_n;
         stop2_a   <= stop2_n;
         stop2_b   <= stop2_n;
         stop2_c   <= stop2_n;
         tx_q      <= tx_n;
         done_q    <= done_n;
         if (load) begin
            shift_reg  <= Data_i;
            parity_q   <= (^Data_i) ^ p_ParityOdd_i;
            par_en_q   <= p_ParityEnable_i;
            stop2_en_q <= StopBits2_i;
         end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
         end
      end
   end

   assign Ready_o      = (state_v == INTERVAL);
   assign Tx_o         = tx_q;
   assign Done_o       = done_q;
   assign State_o      = state_v;
   assign BitCounter_o = bit_cnt_v;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a frame-level model predicts the line level for every
// tick consumed, plus the Done and Ready behaviour, against randomized traffic.
module tb_uart_tx_engine;
   localparam int OS = 16;
   localparam logic [4:0] S_INTERVAL = 5'b00001;
   localparam logic [4:0] S_START    = 5'b00010;
   localparam logic [4:0] S_DATA     = 5'b00100;
   localparam logic [4:0] S_PAR      = 5'b01000;

   logic       clk = 1'b0, rst = 1'b0, Tick_i = 1'b0, Valid_i = 1'b0;
   logic       pe = 1'b0, po = 1'b0, s2 = 1'b0;
   logic [7:0] Data_i = 8'd0;
   logic       Ready_o, Tx_o, Done_o;
   logic [4:0] State_o;
   logic [3:0] BitCounter_o;

   int n_checks = 0, n_pass = 0;

   uart_tx_engine #(.OVERSAMPLE(OS)) dut (
      .clk(clk), .rst(rst), .Tick_i(Tick_i), .Data_i(Data_i), .Valid_i(Valid_i),
      .Ready_o(Ready_o), .p_ParityEnable_i(pe), .p_ParityOdd_i(po), .StopBits2_i(s2),
      .Tx_o(Tx_o), .Done_o(Done_o), .State_o(State_o), .BitCounter_o(BitCounter_o)
   );

   always #5 clk = ~clk;

   int tick_period = 4, tick_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (tick_cnt + 1 >= tick_period) begin Tick_i = 1'b1; tick_cnt = 0; end
      else begin Tick_i = 1'b0; tick_cnt++; end
   end

   // frame model: list of line levels, each held for OS ticks
   logic lev [12];
   int   nlev = 0, j = 0, accepts = 0, dones = 0;
   bit   in_frame = 0, chk_en = 0, chk_exp = 1, exp_done = 0, mute = 1, abort_req = 0;

   function automatic logic level_of(input int idx);
      return (idx < nlev) ? lev[idx] : 1'b1;
   endfunction

   initial forever begin
      @(posedge clk);
      if (!rst) begin
         in_frame = 0; chk_en = 0; exp_done = 0; j = 0;
      end else if (abort_req) begin
         in_frame = 0; chk_en = 0; exp_done = 0; abort_req = 0;
      end else begin
         chk_en   = in_frame;
         chk_exp  = level_of(j / OS);
         exp_done = 0;
         if (in_frame) begin
            if (Tick_i) begin
               j++;
               if (j == nlev * OS) begin exp_done = 1; in_frame = 0; end
            end
         end else if (Valid_i) begin
            lev[0] = 1'b0;
            for (int i = 0; i < 8; i++) lev[1 + i] = Data_i[i];
            nlev = 9;
            if (pe) begin lev[nlev] = (^Data_i) ^ po; nlev++; end
            lev[nlev] = 1'b1; nlev++;
            if (s2) begin lev[nlev] = 1'b1; nlev++; end
            in_frame = 1; j = 0; accepts++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst && Done_o) dones++;
      if (rst && !mute) begin
         if (chk_en) begin
            n_checks++;
            if (Tx_o !== chk_exp) $display("FAIL line_level tick=%0d actual=%b expected=%b", j, Tx_o, chk_exp);
            else n_pass++;
         end
         n_checks++;
         if (Done_o !== exp_done) $display("FAIL done_pulse actual=%b expected=%b", Done_o, exp_done);
         else n_pass++;
         n_checks++;
         if (Ready_o !== !in_frame) $display("FAIL ready actual=%b expected=%b", Ready_o, !in_frame);
         else n_pass++;
      end
   end

   task automatic send(input logic [7:0] d, input logic p_en, input logic p_odd, input logic st2, input bit hold);
      int a0;
      @(negedge clk);
      Data_i = d; pe = p_en; po = p_odd; s2 = st2; Valid_i = 1'b1;
      a0 = accepts;
      for (int k = 0; k < 3000 && accepts == a0; k++) @(negedge clk);
      n_checks++;
      if (accepts == a0) $display("FAIL accept_timeout actual=%0d expected=%0d", accepts, a0 + 1);
      else n_pass++;
      if (!hold) begin
         Valid_i = 1'b0;
         Data_i = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
      end
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 4000 && dones < target; k++) @(negedge clk);
      n_checks++;
      if (dones < target) $display("FAIL done_timeout actual=%0d expected=%0d", dones, target);
      else n_pass++;
   endtask

   task automatic wait_model_bit(input int lo, input int hi, input int max_phase);
      for (int k = 0; k < 4000 && !(in_frame && j / OS >= lo && j / OS <= hi && j % OS <= max_phase); k++)
         @(negedge clk);
      n_checks++;
      if (!(in_frame && j / OS >= lo && j / OS <= hi)) $display("FAIL bit_wait_timeout actual=%0d expected=%0d", j / OS, lo);
      else n_pass++;
   endtask

   task automatic test_reset();
      mute = 1; rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (Tx_o !== 1'b1) $display("FAIL rst_tx actual=%b expected=1", Tx_o); else n_pass++;
      n_checks++; if (Ready_o !== 1'b1) $display("FAIL rst_ready actual=%b expected=1", Ready_o); else n_pass++;
      n_checks++; if (Done_o !== 1'b0) $display("FAIL rst_done actual=%b expected=0", Done_o); else n_pass++;
      n_checks++; if (State_o !== S_INTERVAL) $display("FAIL rst_state actual=%b expected=%b", State_o, S_INTERVAL); else n_pass++;
      n_checks++; if (BitCounter_o !== 4'd0) $display("FAIL rst_bitcnt actual=%0d expected=0", BitCounter_o); else n_pass++;
      @(negedge clk); rst = 1'b1;
      #1 mute = 0;
   endtask

   task automatic test_8n1_0x55();
      int runs [12];
      int r, len, d0;
      logic prev;
      tick_period = 4; d0 = dones;
      send(8'h55, 1'b0, 1'b0, 1'b0, 0);
      r = 0; len = 1; prev = Tx_o;
      for (int k = 0; k < 2000 && r < 10; k++) begin
         @(negedge clk);
         if (Tx_o === prev) len++;
         else begin runs[r] = len; r++; prev = Tx_o; len = 1; end
      end
      for (int b = 2; b < 10; b++) begin
         n_checks++;
         if (runs[b] != 4 * OS) $display("FAIL data_bit_len bit=%0d actual=%0d expected=%0d", b - 2, runs[b], 4 * OS);
         else n_pass++;
      end
      wait_done(d0 + 1);
      repeat (20) @(negedge clk);
      n_checks++; if (dones != d0 + 1) $display("FAIL done_count_8n1 actual=%0d expected=%0d", dones, d0 + 1); else n_pass++;
   endtask

   task automatic test_parity();
      int d0;
      tick_period = $urandom_range(1, 6); d0 = dones;
      send(8'hA3, 1'b1, 1'b0, 1'b0, 0);
      wait_done(d0 + 1);
      send(8'hA3, 1'b1, 1'b1, 1'b0, 0);
      wait_done(d0 + 2);
   endtask

   task automatic test_back_to_back();
      int d0;
      bit seen;
      tick_period = 4; d0 = dones; seen = 0;
      send(8'h0F, 1'b0, 1'b0, 1'b1, 1);
      Data_i = 8'hF0; s2 = 1'($urandom);
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge clk);
         seen = Done_o;
      end
      n_checks++; if (!seen) $display("FAIL b2b_first_done actual=0 expected=1"); else n_pass++;
      @(negedge clk);
      n_checks++; if (State_o !== S_START) $display("FAIL b2b_restart actual=%b expected=%b", State_o, S_START); else n_pass++;
      Valid_i = 1'b0;
      wait_done(d0 + 2);
      repeat (5) @(negedge clk);
      n_checks++; if (dones != d0 + 2) $display("FAIL b2b_done_count actual=%0d expected=%0d", dones, d0 + 2); else n_pass++;
   endtask

   task automatic test_async_reset();
      int d0;
      tick_period = $urandom_range(1, 6);
      send(8'hFF, 1'($urandom), 1'($urandom), 1'b0, 0);
      wait_model_bit(5, 5, OS - 1);
      n_checks++; if (BitCounter_o !== 4'd4) $display("FAIL mid_bitcnt actual=%0d expected=4", BitCounter_o); else n_pass++;
      d0 = dones;
      #2 rst = 1'b0; mute = 1;
      #1;
      n_checks++; if (Tx_o !== 1'b1) $display("FAIL arst_tx actual=%b expected=1", Tx_o); else n_pass++;
      n_checks++; if (State_o !== S_INTERVAL) $display("FAIL arst_state actual=%b expected=%b", State_o, S_INTERVAL); else n_pass++;
      n_checks++; if (BitCounter_o !== 4'd0) $display("FAIL arst_bitcnt actual=%0d expected=0", BitCounter_o); else n_pass++;
      Data_i = 8'h00; pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom); Valid_i = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1 mute = 0;
      @(posedge clk); #1;
      n_checks++; if (State_o !== S_START) $display("FAIL arst_reaccept actual=%b expected=%b", State_o, S_START); else n_pass++;
      n_checks++; if (dones != d0) $display("FAIL arst_no_done actual=%0d expected=%0d", dones, d0); else n_pass++;
      @(negedge clk); Valid_i = 1'b0;
      wait_done(d0 + 1);
   endtask

   task automatic test_tmr();
      int d0;
      tick_period = $urandom_range(1, 6); d0 = dones;
      send(8'($urandom), 1'b1, 1'($urandom), 1'($urandom), 0);
      wait_model_bit(2, 7, OS - 3);
      @(posedge clk); #2;
      force dut.state_b = S_PAR;
      #1;
      n_checks++; if (State_o !== S_DATA) $display("FAIL tmr_vote actual=%b expected=%b", State_o, S_DATA); else n_pass++;
      release dut.state_b;
      @(posedge clk); #1;
      n_checks++; if (dut.state_b !== S_DATA) $display("FAIL tmr_scrub actual=%b expected=%b", dut.state_b, S_DATA); else n_pass++;
      wait_done(d0 + 1);

      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      wait_model_bit(2, 7, OS - 1);
      @(posedge clk); #2;
      mute = 1; abort_req = 1;
      force dut.state_a = 5'b00110;
      force dut.state_b = 5'b00110;
      force dut.state_c = 5'b00110;
      @(posedge clk); #1;
      n_checks++; if (Tx_o !== 1'b1) $display("FAIL illegal_tx actual=%b expected=1", Tx_o); else n_pass++;
      n_checks++; if (Done_o !== 1'b0) $display("FAIL illegal_done actual=%b expected=0", Done_o); else n_pass++;
      n_checks++; if (BitCounter_o !== 4'd0) $display("FAIL illegal_bitcnt actual=%0d expected=0", BitCounter_o); else n_pass++;
      release dut.state_a;
      release dut.state_b;
      release dut.state_c;
      @(posedge clk); #1;
      n_checks++; if (State_o !== S_INTERVAL) $display("FAIL illegal_recover actual=%b expected=%b", State_o, S_INTERVAL); else n_pass++;
      n_checks++; if (dones != d0 + 1) $display("FAIL illegal_done_count actual=%0d expected=%0d", dones, d0 + 1); else n_pass++;
      mute = 0;
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      wait_done(d0 + 2);
   endtask

   task automatic test_random();
      int d0;
      for (int n = 0; n < 6; n++) begin
         tick_period = $urandom_range(1, 6); d0 = dones;
         send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
         wait_done(d0 + 1);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_8n1_0x55();
      test_parity();
      test_back_to_back();
      test_async_reset();
      test_tmr();
      test_random();
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
